// File: rtl/quad_pkg.sv
// Quadrature decoder shared types: phase codes and the
// transition classifier used by the decode stage.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } qdir_t;

  function automatic qdir_t quad_dir(
    input logic [1:0] old_ab,
    input logic [1:0] new_ab
  );
    qdir_t r;
    r = '0;
    unique case (1'b1)
      ((old_ab ^ new_ab) == 2'b11): r.illegal = 1'b1;
      (old_ab == new_ab): ;
      default: begin
        r.valid = 1'b1;
        r.up = (old_ab == PH_00 && new_ab == PH_01) ||
               (old_ab == PH_01 && new_ab == PH_11) ||
               (old_ab == PH_11 && new_ab == PH_10) ||
               (old_ab == PH_10 && new_ab == PH_00);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer plus stability filter for the A/B pair;
// fab only follows s2 once s2 has held one value for FILT clocks.
module quad_sync_filter #(
  parameter int FILT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d_in,
  input  logic       acc_eq,
  output logic [1:0] fab,
  output logic [1:0] fab_new,
  output logic       fab_upd
);

  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] FILT_C = CW'(FILT);

  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;
  logic [1:0]    fab_q, fab_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] stab_q, stab_d;
  logic [CW-1:0] run;

  always_comb begin
    s1_d    = d_in;
    s2_d    = s1_q;
    fab_d   = fab_q;
    cand_d  = s2_q;
    stab_d  = '0;
    fab_upd = 1'b0;
    run     = (s2_q == cand_q) ? stab_q + CW'(1) : CW'(1);
    // acc_eq lets the reset value itself be accepted for priming
    if (s2_q != fab_q || acc_eq) begin
      if (run >= FILT_C) begin
        fab_d   = s2_q;
        fab_upd = 1'b1;
      end else begin
        stab_d = run;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      fab_q  <= '0;
      cand_q <= '0;
      stab_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      fab_q  <= fab_d;
      cand_q <= cand_d;
      stab_q <= stab_d;
    end
  end

  assign fab     = fab_q;
  assign fab_new = s2_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive a loadable
// up/down position count with step, dir and sticky err flags.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FILT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en_load,
  input  logic [WIDTH-1:0] load,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [1:0] fab, fab_new;
  logic       fab_upd;
  qdir_t      qd;
  logic       mv, bad;

  logic             primed_q, primed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  quad_sync_filter #(.FILT(FILT)) u_filt (
    .clk     (clk),
    .rst_n   (reset),
    .d_in    ({a_in, b_in}),
    .acc_eq  (!primed_q),
    .fab     (fab),
    .fab_new (fab_new),
    .fab_upd (fab_upd)
  );

  always_comb begin
    qd       = quad_dir(fab, fab_new);
    mv       = fab_upd && primed_q && qd.valid;
    bad      = fab_upd && primed_q && qd.illegal;
    primed_d = primed_q | fab_upd;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = err_q;
    // a load beats a coincident step; the filter still tracks fab
    unique case (1'b1)
      en_load: cnt_d = load;
      (mv && !en_load): begin
        cnt_d  = qd.up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        dir_d  = qd.up;
        step_d = 1'b1;
      end
      default: ;
    endcase
    if (bad) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed_q <= 1'b0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: vector table for the phase walk plus
// a step scoreboard keyed on the expected output cycle.
module tb_quad_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a_in = 1'b0;
  logic         b_in = 1'b0;
  logic         en_load = 1'b0;
  logic [W-1:0] load = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] cnt;
  logic         dir;
  logic         step;
  logic         err;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(W), .FILT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .en_load (en_load),
    .load    (load),
    .clr_err (clr_err),
    .cnt     (cnt),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         dir;
  } exp_t;

  typedef struct {
    logic [1:0]   ab;
    logic [W-1:0] cnt;
    logic         dir;
    logic         err;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [1:0]   m_fab;
  logic [W-1:0] m_cnt;
  logic         m_dir;
  logic         m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] up_next(input logic [1:0] x);
    case (x)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // step monitor: every pulse must match the head of the scoreboard
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_step: cyc %0d cnt %0h, expected no step", cyc, cnt);
      end else begin
        e = sb.pop_front();
        chk("step_cycle", cyc, e.cyc);
        chk("step_cnt", {24'd0, cnt}, {24'd0, e.cnt});
        chk("step_dir", {31'd0, dir}, {31'd0, e.dir});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_step(input int c, input logic [W-1:0] v, input logic d);
    exp_t e;
    e.cyc = c;
    e.cnt = v;
    e.dir = d;
    sb.push_back(e);
  endtask

  task automatic drive_ab(input logic [1:0] ab, input bit push);
    @(posedge clk);
    #2;
    {a_in, b_in} = ab;
    if (ab != m_fab) begin
      if (up_next(m_fab) == ab) begin
        if (push) begin
          m_cnt++;
          m_dir = 1'b1;
          push_step(cyc + 5, m_cnt, m_dir);
        end
      end else if (up_next(ab) == m_fab) begin
        if (push) begin
          m_cnt--;
          m_dir = 1'b0;
          push_step(cyc + 5, m_cnt, m_dir);
        end
      end else begin
        m_err = 1'b1;
      end
      m_fab = ab;
    end
  endtask

  task automatic do_reset(input logic [1:0] ab);
    reset = 1'b0;
    {a_in, b_in} = ab;
    en_load = 1'b0;
    clr_err = 1'b0;
    m_cnt = '0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_fab = ab;
    wait_clk(3);
    chk("rst_cnt", {24'd0, cnt}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    wait_clk(20);
  endtask

  initial begin
    int c0;

    do_reset(2'b11);
    chk("prime11_cnt", {24'd0, cnt}, 32'd0);
    chk("prime11_err", {31'd0, err}, 32'd0);

    do_reset(2'b00);
    tbl[0] = '{2'b01, 8'h01, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 8'h02, 1'b1, 1'b0};
    tbl[2] = '{2'b10, 8'h03, 1'b1, 1'b0};
    tbl[3] = '{2'b00, 8'h04, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 8'h03, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 8'h02, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 8'h01, 1'b0, 1'b0};
    tbl[7] = '{2'b00, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{2'b10, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{2'b00, 8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_ab(tbl[i].ab, 1'b1);
      wait_clk(10);
      chk($sformatf("vec%0d_cnt", i), {24'd0, cnt}, {24'd0, tbl[i].cnt});
      chk($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, tbl[i].dir});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
    end

    // load FF then step up wraps to 00
    @(posedge clk);
    #2;
    en_load = 1'b1;
    load = 8'hFF;
    wait_clk(1);
    en_load = 1'b0;
    m_cnt = 8'hFF;
    chk("load_ff", {24'd0, cnt}, 32'hFF);
    drive_ab(2'b01, 1'b1);
    wait_clk(10);
    chk("wrap_cnt", {24'd0, cnt}, 32'h00);
    chk("wrap_dir", {31'd0, dir}, 32'd1);
    drive_ab(2'b00, 1'b1);
    wait_clk(10);
    chk("down_cnt", {24'd0, cnt}, 32'hFF);

    // 2-clock glitch on a_in is rejected
    @(posedge clk);
    #2;
    a_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    a_in = 1'b0;
    wait_clk(12);
    chk("glitch2_cnt", {24'd0, cnt}, 32'hFF);
    chk("glitch2_dir", {31'd0, dir}, 32'd0);

    // 3-clock pulse is accepted: down then back up
    @(posedge clk);
    #2;
    a_in = 1'b1;
    c0 = cyc;
    push_step(c0 + 5, 8'hFE, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    a_in = 1'b0;
    push_step(c0 + 8, 8'hFF, 1'b1);
    m_dir = 1'b1;
    wait_clk(12);
    chk("pulse3_cnt", {24'd0, cnt}, 32'hFF);
    chk("pulse3_dir", {31'd0, dir}, 32'd1);

    // illegal 00->11 and error clear
    drive_ab(2'b11, 1'b1);
    wait_clk(10);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_cnt", {24'd0, cnt}, 32'hFF);
    @(posedge clk);
    #2;
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    m_err = 1'b0;
    wait_clk(2);
    chk("clr_err", {31'd0, err}, 32'd0);

    // clr_err on the same edge as a new illegal transition
    drive_ab(2'b00, 1'b1);
    wait_clk(4);
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    chk("clr_vs_illegal", {31'd0, err}, 32'd1);
    wait_clk(8);
    chk("err_sticky", {31'd0, err}, {31'd0, m_err});
    chk("illegal2_cnt", {24'd0, cnt}, 32'hFF);

    // load on the step edge suppresses the step
    drive_ab(2'b01, 1'b0);
    wait_clk(4);
    en_load = 1'b1;
    load = 8'h5A;
    wait_clk(1);
    en_load = 1'b0;
    m_cnt = 8'h5A;
    chk("ldstep_cnt", {24'd0, cnt}, 32'h5A);
    chk("ldstep_step", {31'd0, step}, 32'd0);
    chk("ldstep_dir", {31'd0, dir}, {31'd0, m_dir});
    wait_clk(10);
    drive_ab(2'b11, 1'b1);
    wait_clk(10);
    chk("after_load_cnt", {24'd0, cnt}, 32'h5B);

    // reset in the middle of a pending step
    drive_ab(2'b10, 1'b0);
    wait_clk(2);
    reset = 1'b0;
    #1;
    chk("midrst_cnt", {24'd0, cnt}, 32'd0);
    chk("midrst_dir", {31'd0, dir}, 32'd0);
    chk("midrst_step", {31'd0, step}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    m_cnt = '0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_fab = 2'b10;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(20);
    chk("reprime_cnt", {24'd0, cnt}, 32'd0);
    drive_ab(2'b00, 1'b1);
    wait_clk(10);
    chk("reprime_step_cnt", {24'd0, cnt}, {24'd0, m_cnt});
    chk("reprime_dir", {31'd0, dir}, 32'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
